mbox_spi_master: RTL and testbench

- Downstream consumer of the COSMAC memory/controller's mailbox window (0xF000–0xF008). It holds an 8-byte TX buffer written by the bus side and an 8-byte RX buffer read back by it.
- On a write to TX index 7, it waits for the peer's ready line, then runs one 64-bit full-duplex SPI mode-0 transfer and posts the received bytes with a valid flag.

---
 rtl/mbox_pkg.sv | 18 +
 rtl/mbox_sync2.sv | 21 ++
 rtl/mbox_spi_master.sv | 187 ++++++++++++++++++
 tb/tb_mbox_spi_master.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbox_pkg.sv
// Shared types and constants for the COSMAC mailbox SPI master.
package mbox_pkg;

    localparam int          MBOX_IDX_W       = 3;
    localparam int          MBOX_BYTES       = 8;
    localparam logic [15:0] MBOX_BASE_ADDR   = 16'hF000;
    localparam logic [15:0] MBOX_STATUS_ADDR = 16'hF008;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } mbox_state_e;

endpackage

// File: rtl/mbox_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module mbox_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/mbox_spi_master.sv
// Mailbox-fed 64-bit full-duplex SPI mode-0 master.
// Define MBOX_LOOPBACK_EN to loop mosi back to the receiver and ignore ready.
module mbox_spi_master
    import mbox_pkg::*;
#(
    parameter int SCLK_DIV = 4,
    parameter int NBYTES   = MBOX_BYTES
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    input  logic                  ready,
    output logic                  cs,
    input  logic [MBOX_IDX_W-1:0] rindex,
    input  logic [MBOX_IDX_W-1:0] windex,
    output logic [7:0]            rdata,
    input  logic [7:0]            wdata,
    input  logic                  wstrb,
    output logic                  valid,
    output logic                  busy
);

    localparam int                NBITS    = NBYTES * 8;
    localparam int                HC_W     = $clog2(SCLK_DIV);
    localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(SCLK_DIV - 1);
    localparam logic [6:0]        BIT_LAST = 7'(NBITS - 1);
    localparam logic [MBOX_IDX_W-1:0] LAST_IDX = MBOX_IDX_W'(NBYTES - 1);

    mbox_state_e      state_q, state_d;
    logic [7:0]       tx_buf_q [NBYTES];
    logic [7:0]       rx_buf_q [NBYTES];
    logic [NBITS-1:0] tx_frame;
    logic [NBITS-1:0] tx_sh_q, tx_sh_d;
    logic [NBITS-1:0] rx_sh_q, rx_sh_d;
    logic [HC_W-1:0]  hcnt_q, hcnt_d;
    logic [6:0]       bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             pending_q, pending_d;
    logic             valid_q, valid_d;
    logic             rx_load;
    logic             wr_ok;
    logic             ready_s;
    logic             miso_src;

`ifdef MBOX_LOOPBACK_EN
    assign ready_s  = 1'b1;
    assign miso_src = tx_sh_q[NBITS-1];
`else
    mbox_sync2 u_ready_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (ready),
        .q_o    (ready_s)
    );
    assign miso_src = miso;
`endif

    assign wr_ok = wstrb && !pending_q;

    always_comb begin
        for (int i = 0; i < NBYTES; i++) begin
            tx_frame[NBITS-1-8*i -: 8] = tx_buf_q[i];
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        rx_load   = 1'b0;
        cs        = 1'b1;

        if (wr_ok && windex == LAST_IDX) begin
            pending_d = 1'b1;
            valid_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (ready_s) begin
                    state_d   = SETUP;
                    hcnt_d    = '0;
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                    tx_sh_d   = tx_frame;
                end
            end
            SETUP: begin
                cs     = 1'b0;
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_q == HC_LAST) begin
                    hcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cs     = 1'b0;
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_q == HC_LAST) begin
                    hcnt_d = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[NBITS-2:0], miso_src};
                    end else begin
                        // Falling edge: present the next bit; the counter parks at 64.
                        tx_sh_d   = {tx_sh_q[NBITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                cs     = 1'b0;
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_q == HC_LAST) begin
                    hcnt_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                rx_load   = 1'b1;
                pending_d = 1'b0;
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!resetn) begin
            state_q   <= IDLE;
            hcnt_q    <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
        end
    end

    // NOTE: both buffers are small register files and are cleared on reset so rdata is never X.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NBYTES; i++) tx_buf_q[i] <= 8'h00;
        end else if (wr_ok) begin
            tx_buf_q[windex] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NBYTES; i++) rx_buf_q[i] <= 8'h00;
        end else if (rx_load) begin
            for (int i = 0; i < NBYTES; i++) rx_buf_q[i] <= rx_sh_q[NBITS-1-8*i -: 8];
        end
    end

    assign sclk  = sclk_q;
    assign mosi  = tx_sh_q[NBITS-1];
    assign rdata = rx_buf_q[rindex];
    assign valid = valid_q;
    assign busy  = pending_q;

endmodule

// File: tb/tb_mbox_spi_master.sv
// Directed self-checking bench for mbox_spi_master with a mode-0 slave model.
module tb_mbox_spi_master;

    localparam int SCLK_DIV = 4;
`ifdef MBOX_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif
    localparam logic [63:0] TX_A = 64'h1122334455667788;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       ready  = 1'b1;
    logic       wstrb  = 1'b0;
    logic [2:0] rindex = 3'd0;
    logic [2:0] windex = 3'd0;
    logic [7:0] wdata  = 8'h00;
    logic       miso;
    logic       sclk, mosi, cs, valid, busy;
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;

    mbox_spi_master #(.SCLK_DIV(SCLK_DIV)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sclk   (sclk),
        .mosi   (mosi),
        .miso   (miso),
        .ready  (ready),
        .cs     (cs),
        .rindex (rindex),
        .windex (windex),
        .rdata  (rdata),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Slave model: shifts slv_pat out on falling sclk, records mosi on rising sclk.
    logic [63:0] slv_pat   = 64'd0;
    logic [63:0] slv_view;
    logic [63:0] mosi_cap  = 64'd0;
    logic [63:0] mosi_last = 64'd0;
    int          rise_cnt  = 0;
    int          fall_cnt  = 0;

    assign slv_view = slv_pat << fall_cnt;
    assign miso     = slv_view[63];

    always @(posedge cs or posedge sclk) begin
        if (cs) begin
            mosi_last = mosi_cap;
            mosi_cap  = 64'd0;
            rise_cnt  = 0;
        end else begin
            mosi_cap = {mosi_cap[62:0], mosi};
            rise_cnt++;
        end
    end

    always @(posedge cs or negedge sclk) begin
        if (cs) fall_cnt = 0;
        else    fall_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] d);
        @(negedge clk);
        windex = idx;
        wdata  = d;
        wstrb  = 1'b1;
        @(negedge clk);
        wstrb  = 1'b0;
    endtask

    task automatic write_tx(input logic [63:0] v);
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(v >> (8 * (7 - i))));
    endtask

    task automatic wait_done(output int cs_low);
        int n;
        n      = 0;
        cs_low = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
            if (!cs) cs_low++;
        end
        check("done_timeout", 64'(busy), 64'd0);
    endtask

    task automatic check_rx(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 8; i++) begin
            rindex = 3'(i);
            #1;
            check($sformatf("%s_rdata%0d", tag, i), 64'(rdata), 64'(8'(exp >> (8 * (7 - i)))));
        end
    endtask

    function automatic logic [63:0] exp_rx(input logic [63:0] tx, input logic [63:0] slv);
        return LOOPBACK ? tx : slv;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_low;
        int n;
        bit cs_high;

        // Reset state
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_cs",    64'(cs),    64'd1);
        check("rst_sclk",  64'(sclk),  64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_mosi",  64'(mosi),  64'd0);
        check_rx("rst", 64'd0);
        resetn = 1'b1;

        // Basic frame
        slv_pat = 64'hA0A1A2A3A4A5A6A7;
        write_tx(TX_A);
        check("basic_busy", 64'(busy), 64'd1);
        wait_done(cs_low);
        check("basic_cs_low", 64'(cs_low), 64'd520);
        check("basic_mosi",   mosi_last,   TX_A);
        check("basic_valid",  64'(valid),  64'd1);
        check("basic_busy0",  64'(busy),   64'd0);
        check_rx("basic", exp_rx(TX_A, slv_pat));

        // Ready gating
        if (!LOOPBACK) begin
            ready = 1'b0;
            repeat (3) @(negedge clk);
            wr(3'd7, 8'h88);
            check("gate_valid_clr", 64'(valid), 64'd0);
            cs_high = 1'b1;
            repeat (100) begin
                @(negedge clk);
                if (!cs) cs_high = 1'b0;
            end
            check("gate_cs_high", 64'(cs_high), 64'd1);
            check("gate_busy",    64'(busy),    64'd1);
            ready = 1'b1;
            n = 0;
            while (cs && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("gate_ready_to_cs", 64'(n), 64'd3);
            wait_done(cs_low);
            check("gate_mosi",  mosi_last,  TX_A);
            check("gate_valid", 64'(valid), 64'd1);
        end

        // Writes while busy are dropped
        slv_pat = 64'h0F1E2D3C4B5A6978;
        wr(3'd7, 8'h88);
        repeat (100) @(negedge clk);
        check("drop_in_frame", 64'(cs), 64'd0);
        wr(3'd2, 8'hFF);
        wr(3'd7, 8'h55);
        wait_done(cs_low);
        check("drop_cur_mosi", mosi_last, TX_A);
        check_rx("drop", exp_rx(TX_A, slv_pat));
        repeat (3) @(negedge clk);
        check("drop_idle", 64'(busy), 64'd0);
        wr(3'd7, 8'h88);
        wait_done(cs_low);
        check("drop_next_mosi", mosi_last, TX_A);

        // Reset in the middle of a frame
        wr(3'd7, 8'h88);
        n = 0;
        while (rise_cnt < 30 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_bit30", 64'(rise_cnt), 64'd30);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_cs",   64'(cs),   64'd1);
        check("mid_sclk", 64'(sclk), 64'd0);
        @(negedge clk);
        check("mid_valid", 64'(valid), 64'd0);
        check("mid_busy",  64'(busy),  64'd0);
        check_rx("mid", 64'd0);
        resetn = 1'b1;

        // Loopback frame returns tx_buf unchanged
        if (LOOPBACK) begin
            write_tx(64'hDEADBEEF01020304);
            wait_done(cs_low);
            check("lb_valid", 64'(valid), 64'd1);
            check_rx("lb", 64'hDEADBEEF01020304);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
